// File: rtl/snake_pkg.sv
// Shared direction encoding and turn-legality helper for the snake controller.
package snake_pkg;
  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RIGHT = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_UP    = 2'b11;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_R = 2;
  localparam int BTN_L = 3;
  localparam int BTN_C = 4;
  localparam int NUM_BTNS = 5;

  // Horizontal and vertical directions differ in bit 0.
  function automatic logic is_perp(input dir_t a, input dir_t b);
    return a[0] != b[0];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// Debounces one raw button and emits a one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;

  // Count consecutive cycles where raw disagrees with level; any agreement restarts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (raw_i != level_q) begin
        if (cnt_q == LAST) begin
          level_q <= raw_i;
          cnt_q   <= '0;
          press_q <= raw_i;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: debounced buttons feed a small turn queue drained by GAME_TICK.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         QUEUE_DEPTH     = 2,
  parameter logic [1:0] INIT_DIR        = 2'b00,
  parameter int         PAUSE_EN        = 1
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               BTNU,
  input  logic                               BTND,
  input  logic                               BTNL,
  input  logic                               BTNR,
  input  logic                               BTNC,
  input  logic                               GAME_TICK,
  output logic [1:0]                         DIR,
  output logic                               PAUSED,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   QUEUE_LEVEL,
  output logic                               TURN_DROPPED
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int LW = $clog2(QUEUE_DEPTH + 1);

  logic [NUM_BTNS-1:0] raw, press, lvl_unused;

  assign raw = {BTNC, BTNL, BTNR, BTND, BTNU};

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i  (CLK),
      .rst_ni (RESET),
      .raw_i  (raw[b]),
      .level_o(lvl_unused[b]),
      .press_o(press[b])
    );
  end

  dir_t          q_q [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] lvl_q;
  dir_t          dir_q;
  logic          paused_q, drop_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  dir_t          cand, ref_dir;
  logic          cand_vld, accept, pop, push, drop, full;
  logic [PW-1:0] tail_idx;

  always_comb begin
    cand     = DIR_LEFT;
    cand_vld = 1'b0;
    if (!paused_q) begin
      if (press[BTN_U])      begin cand = DIR_UP;    cand_vld = 1'b1; end
      else if (press[BTN_D]) begin cand = DIR_DOWN;  cand_vld = 1'b1; end
      else if (press[BTN_R]) begin cand = DIR_RIGHT; cand_vld = 1'b1; end
      else if (press[BTN_L]) begin cand = DIR_LEFT;  cand_vld = 1'b1; end
    end
  end

  // Legality is judged against the last queued turn, not the applied one.
  assign tail_idx = (wr_ptr_q == '0) ? PW'(QUEUE_DEPTH - 1) : wr_ptr_q - 1'b1;
  assign ref_dir  = (lvl_q != '0) ? q_q[tail_idx] : dir_q;
  assign full     = (lvl_q == LW'(QUEUE_DEPTH));
  assign pop      = GAME_TICK && !paused_q && (lvl_q != '0);
  assign accept   = cand_vld && is_perp(cand, ref_dir);
  assign push     = accept && (!full || pop);
  assign drop     = accept && !push;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      dir_q    <= INIT_DIR;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      lvl_q    <= '0;
      paused_q <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q_q[i] <= DIR_RIGHT;
    end else begin
      drop_q <= drop;
      if (press[BTN_C] && (PAUSE_EN != 0)) paused_q <= ~paused_q;
      if (pop) begin
        dir_q    <= q_q[rd_ptr_q];
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push) begin
        q_q[wr_ptr_q] <= cand;
        wr_ptr_q      <= ptr_inc(wr_ptr_q);
      end
      if (push && !pop)      lvl_q <= lvl_q + 1'b1;
      else if (pop && !push) lvl_q <= lvl_q - 1'b1;
    end
  end

  assign DIR          = dir_q;
  assign PAUSED       = paused_q;
  assign QUEUE_LEVEL  = lvl_q;
  assign TURN_DROPPED = drop_q;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with short debounce and a two-entry queue.
module tb_snake_dir_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn;
  logic       tick;
  logic [1:0] dir;
  logic       paused;
  logic [1:0] qlvl;
  logic       dropped;
  int         checks = 0;
  int         failures = 0;
  int         drop_cnt = 0;
  int         d0;

  always #5 clk = ~clk;

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .QUEUE_DEPTH    (2),
    .INIT_DIR       (2'b00),
    .PAUSE_EN       (1)
  ) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .BTNU        (btn[0]),
    .BTND        (btn[1]),
    .BTNL        (btn[3]),
    .BTNR        (btn[2]),
    .BTNC        (btn[4]),
    .GAME_TICK   (tick),
    .DIR         (dir),
    .PAUSED      (paused),
    .QUEUE_LEVEL (qlvl),
    .TURN_DROPPED(dropped)
  );

  always @(posedge clk) if (dropped) drop_cnt <= drop_cnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn = '0; tick = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Hold a button pattern long enough for one press, then release fully.
  task automatic press(input logic [4:0] m);
    btn = m;  step(5);
    btn = '0; step(5);
  endtask

  task automatic do_tick();
    tick = 1'b1; step(1); tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; btn = '0; tick = 1'b0;

    // Reset state
    do_reset();
    chk("rst_dir", dir, 0);
    chk("rst_qlvl", qlvl, 0);
    chk("rst_paused", paused, 0);
    chk("rst_drop", dropped, 0);

    // Bounce: 3 high, 1 low, then stable high
    btn[0] = 1'b1; step(3);
    btn[0] = 1'b0; step(1);
    btn[0] = 1'b1; step(3);
    chk("bounce_3rd", qlvl, 0);
    step(1);
    chk("bounce_4th", qlvl, 0);
    step(1);
    chk("bounce_push", qlvl, 1);
    step(3);
    chk("bounce_once", qlvl, 1);
    btn = '0; step(5);

    // Reverse and same direction ignored
    do_reset();
    d0 = drop_cnt;
    press(5'b01000);
    press(5'b00100);
    chk("rev_qlvl", qlvl, 0);
    chk("rev_drop", drop_cnt - d0, 0);
    chk("rev_dir", dir, 0);

    // Queued turns
    do_reset();
    press(5'b00001);
    chk("q_lvl1", qlvl, 1);
    press(5'b01000);
    chk("q_lvl2", qlvl, 2);
    do_tick();
    chk("q_dir_up", dir, 3);
    chk("q_lvl_a", qlvl, 1);
    do_tick();
    chk("q_dir_left", dir, 2);
    chk("q_lvl_b", qlvl, 0);

    // Overflow, then push coinciding with a pop
    do_reset();
    press(5'b00001);
    press(5'b01000);
    d0 = drop_cnt;
    press(5'b00010);
    chk("ovf_drop", drop_cnt - d0, 1);
    chk("ovf_qlvl", qlvl, 2);
    btn[1] = 1'b1; step(4);
    tick = 1'b1; step(1); tick = 1'b0;
    chk("ovf_pp_dir", dir, 3);
    chk("ovf_pp_qlvl", qlvl, 2);
    btn = '0; step(5);
    chk("ovf_pp_drop", drop_cnt - d0, 1);
    do_tick();
    chk("ovf_dir_l", dir, 2);
    do_tick();
    chk("ovf_dir_d", dir, 1);
    chk("ovf_empty", qlvl, 0);

    // Push onto empty queue in the tick cycle waits for the next tick
    do_reset();
    btn[0] = 1'b1; step(4);
    tick = 1'b1; step(1); tick = 1'b0;
    chk("sametick_dir", dir, 0);
    chk("sametick_qlvl", qlvl, 1);
    btn = '0; step(5);
    do_tick();
    chk("sametick_next", dir, 3);

    // Priority: U beats D
    do_reset();
    press(5'b00011);
    chk("prio_qlvl", qlvl, 1);
    do_tick();
    chk("prio_dir", dir, 3);

    // Pause
    do_reset();
    press(5'b10000);
    chk("pause_on", paused, 1);
    press(5'b00001);
    do_tick(); do_tick(); do_tick();
    chk("pause_dir", dir, 0);
    chk("pause_qlvl", qlvl, 0);
    press(5'b10000);
    chk("pause_off", paused, 0);
    press(5'b00001);
    do_tick();
    chk("unpause_dir", dir, 3);

    // Reset mid-operation
    do_reset();
    press(5'b00001);
    press(5'b01000);
    press(5'b10000);
    chk("mid_qlvl", qlvl, 2);
    chk("mid_paused", paused, 1);
    d0 = drop_cnt;
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    chk("mid_dir", dir, 0);
    chk("mid_qlvl0", qlvl, 0);
    chk("mid_paused0", paused, 0);
    step(3);
    chk("mid_nodrop", drop_cnt - d0, 0);

    // Button held through reset
    rst_n = 1'b0; btn = 5'b00001; step(2);
    rst_n = 1'b1;
    step(4);
    chk("held_early", qlvl, 0);
    step(1);
    chk("held_push", qlvl, 1);
    btn = '0; step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
